// File: rtl/i2c_slave_regif_ext.sv
// I2C/SMBus slave front-end for CPLD register files.
// Filtered pins, masked address match, 1/2-byte offset, auto-increment, SCL-low timeout.
module i2c_slave_regif_ext #(
  parameter int OFFSET_BYTES = 1,
  parameter int AUTO_INC     = 1,
  parameter int FILT_DEPTH   = 3,
  parameter int TIMEOUT_CYC  = 0,
  localparam int OFF_W       = 8 * OFFSET_BYTES
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [6:0]       i2c_slave_addr,
  input  logic [6:0]       addr_mask,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic [OFF_W-1:0] offset,
  output logic [7:0]       wr_data,
  output logic             wr_en,
  output logic             rd_en,
  input  logic [7:0]       rd_data,
  output logic [6:0]       addr_hit,
  output logic             start,
  output logic             stop,
  output logic             timeout,
  output logic             busy
);

  localparam int CW = $clog2(FILT_DEPTH + 1);

  typedef enum logic [3:0] {
    IDLE, ADR, ADR_ACK, OFF, OFF_ACK,
    WDAT, WDAT_ACK, RDAT, RDAT_ACK, IGNORE
  } state_t;

  // bit 1 = SCL, bit 0 = SDA
  logic [1:0] s1_q, s1_d, s2_q, s2_d;
  logic [1:0] flt_q, flt_d, prv_q, prv_d;
  logic [1:0][CW-1:0] fc_q, fc_d;

  state_t           state_q, state_d;
  logic [3:0]       bc_q, bc_d;
  logic [7:0]       sh_q, sh_d;
  logic             rw_q, rw_d;
  logic             ocnt_q, ocnt_d;
  logic             mack_q, mack_d;
  logic             inc_q, inc_d;
  logic [OFF_W-1:0] offset_q, offset_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             wr_en_q, wr_en_d;
  logic             rd_en_q, rd_en_d;
  logic [6:0]       addr_hit_q, addr_hit_d;
  logic             oe_q, oe_d;
  logic             start_q, start_d;
  logic             stop_q, stop_d;
  logic             to_q, to_d;
  logic [31:0]      tcnt_q, tcnt_d;

  logic             scl_f, sda_f;
  logic             scl_pos, scl_neg;
  logic             start_det, stop_det;
  logic             match, byte_done, ack_done, last_off;
  logic [OFF_W+7:0] off_cat;

  assign scl_f     = flt_q[1];
  assign sda_f     = flt_q[0];
  assign scl_pos   = flt_q[1] & ~prv_q[1];
  assign scl_neg   = ~flt_q[1] & prv_q[1];
  assign start_det = prv_q[0] & ~flt_q[0] & flt_q[1] & prv_q[1];
  assign stop_det  = ~prv_q[0] & flt_q[0] & flt_q[1] & prv_q[1];
  assign match     = ((sh_q[7:1] ^ i2c_slave_addr) & ~addr_mask) == 7'd0;
  assign byte_done = scl_neg && (bc_q == 4'd8);
  assign ack_done  = scl_neg && (bc_q == 4'd1);
  assign last_off  = int'(ocnt_q) == OFFSET_BYTES - 1;
  assign off_cat   = {offset_q, sh_q};

  // Synchroniser plus per-line run-length glitch filter
  always_comb begin
    s1_d  = {scl_i, sda_i};
    s2_d  = s1_q;
    prv_d = flt_q;
    flt_d = flt_q;
    fc_d  = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != flt_q[i]) begin
        if (fc_q[i] == CW'(FILT_DEPTH - 1)) flt_d[i] = s2_q[i];
        else fc_d[i] = fc_q[i] + CW'(1);
      end
    end
  end

  // Filter registers; idle bus levels are high
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_q  <= 2'b11;
      s2_q  <= 2'b11;
      flt_q <= 2'b11;
      prv_q <= 2'b11;
      fc_q  <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      flt_q <= flt_d;
      prv_q <= prv_d;
      fc_q  <= fc_d;
    end
  end

  // Protocol FSM: sample on SCL rise, move/drive on SCL fall
  always_comb begin
    state_d    = state_q;
    bc_d       = bc_q;
    sh_d       = sh_q;
    rw_d       = rw_q;
    ocnt_d     = ocnt_q;
    mack_d     = mack_q;
    inc_d      = 1'b0;
    offset_d   = offset_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    addr_hit_d = addr_hit_q;
    oe_d       = oe_q;
    start_d    = start_det;
    stop_d     = stop_det;
    to_d       = 1'b0;
    tcnt_d     = '0;
    if (inc_q) offset_d = offset_q + OFF_W'(1);
    if (scl_pos) bc_d = bc_q + 4'd1;
    unique case (state_q)
      ADR: begin
        if (scl_pos) sh_d = {sh_q[6:0], sda_f};
        if (byte_done) begin
          bc_d = '0;
          if (match) begin
            state_d    = ADR_ACK;
            addr_hit_d = sh_q[7:1];
            rw_d       = sh_q[0];
            oe_d       = 1'b1;
          end else begin
            state_d = IGNORE;
          end
        end
      end
      ADR_ACK: begin
        if (scl_pos) rd_en_d = rw_q;
        if (ack_done) begin
          bc_d = '0;
          if (rw_q) begin
            state_d = RDAT;
            sh_d    = rd_data;
            oe_d    = ~rd_data[7];
          end else begin
            state_d = OFF;
            ocnt_d  = 1'b0;
            oe_d    = 1'b0;
          end
        end
      end
      OFF: begin
        if (scl_pos) sh_d = {sh_q[6:0], sda_f};
        if (byte_done) begin
          bc_d     = '0;
          offset_d = off_cat[OFF_W-1:0];
          state_d  = OFF_ACK;
          oe_d     = 1'b1;
        end
      end
      OFF_ACK: begin
        if (ack_done) begin
          bc_d = '0;
          oe_d = 1'b0;
          if (last_off) begin
            state_d = WDAT;
          end else begin
            state_d = OFF;
            ocnt_d  = 1'b1;
          end
        end
      end
      WDAT: begin
        if (scl_pos) sh_d = {sh_q[6:0], sda_f};
        if (byte_done) begin
          bc_d    = '0;
          state_d = WDAT_ACK;
          oe_d    = 1'b1;
        end
      end
      WDAT_ACK: begin
        if (scl_pos) begin
          wr_data_d = sh_q;
          wr_en_d   = 1'b1;
          inc_d     = AUTO_INC != 0;
        end
        if (ack_done) begin
          bc_d    = '0;
          state_d = WDAT;
          oe_d    = 1'b0;
        end
      end
      RDAT: begin
        if (byte_done) begin
          bc_d    = '0;
          state_d = RDAT_ACK;
          oe_d    = 1'b0;
        end else if (scl_neg) begin
          sh_d = {sh_q[6:0], 1'b0};
          oe_d = ~sh_q[6];
        end
      end
      RDAT_ACK: begin
        if (scl_pos) begin
          mack_d = ~sda_f;
          if (!sda_f) begin
            rd_en_d = 1'b1;
            if (AUTO_INC != 0) offset_d = offset_q + OFF_W'(1);
          end
        end
        if (ack_done) begin
          bc_d = '0;
          if (mack_q) begin
            state_d = RDAT;
            sh_d    = rd_data;
            oe_d    = ~rd_data[7];
          end else begin
            state_d = IGNORE;
            oe_d    = 1'b0;
          end
        end
      end
      default: ;
    endcase
    if (start_det) begin
      state_d = ADR;
      bc_d    = '0;
      oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d = IDLE;
      bc_d    = '0;
      oe_d    = 1'b0;
    end
    if (TIMEOUT_CYC != 0 && state_q != IDLE && !scl_f) begin
      tcnt_d = tcnt_q + 32'd1;
      if (tcnt_d >= 32'(TIMEOUT_CYC)) begin
        state_d = IDLE;
        bc_d    = '0;
        oe_d    = 1'b0;
        to_d    = 1'b1;
        tcnt_d  = '0;
      end
    end
  end

  // FSM and output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      bc_q       <= '0;
      sh_q       <= '0;
      rw_q       <= 1'b0;
      ocnt_q     <= 1'b0;
      mack_q     <= 1'b0;
      inc_q      <= 1'b0;
      offset_q   <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_hit_q <= '0;
      oe_q       <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      to_q       <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      bc_q       <= bc_d;
      sh_q       <= sh_d;
      rw_q       <= rw_d;
      ocnt_q     <= ocnt_d;
      mack_q     <= mack_d;
      inc_q      <= inc_d;
      offset_q   <= offset_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      addr_hit_q <= addr_hit_d;
      oe_q       <= oe_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      to_q       <= to_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign sda_oe   = oe_q;
  assign offset   = offset_q;
  assign wr_data  = wr_data_q;
  assign wr_en    = wr_en_q;
  assign rd_en    = rd_en_q;
  assign addr_hit = addr_hit_q;
  assign start    = start_q;
  assign stop     = stop_q;
  assign timeout  = to_q;
  assign busy     = state_q != IDLE;

endmodule

// File: tb/tb_i2c_slave_regif_ext.sv
// Directed bench for i2c_slave_regif_ext.
// Two slaves share one bus: A (1-byte offset, addr 0x28) and B (2-byte offset, timeout, addr 0x50).
module tb_i2c_slave_regif_ext;

  localparam int Q = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst, scl_m, sda_m;
  logic [6:0] addr_a, mask_a;
  logic [7:0] rd_data_a, rd_data_b;

  logic        sda_oe_a, wr_en_a, rd_en_a, start_a, stop_a, timeout_a, busy_a;
  logic [7:0]  offset_a, wr_data_a;
  logic [6:0]  addr_hit_a;
  logic        sda_oe_b, wr_en_b, rd_en_b, start_b, stop_b, timeout_b, busy_b;
  logic [15:0] offset_b;
  logic [7:0]  wr_data_b;
  logic [6:0]  addr_hit_b;

  wire sda_bus = sda_m & ~sda_oe_a & ~sda_oe_b;

  int checks = 0;
  int failures = 0;

  i2c_slave_regif_ext #(
    .OFFSET_BYTES(1), .AUTO_INC(1), .FILT_DEPTH(3), .TIMEOUT_CYC(0)
  ) u_a (
    .clk(clk), .nrst(nrst),
    .i2c_slave_addr(addr_a), .addr_mask(mask_a),
    .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe_a),
    .offset(offset_a), .wr_data(wr_data_a), .wr_en(wr_en_a),
    .rd_en(rd_en_a), .rd_data(rd_data_a), .addr_hit(addr_hit_a),
    .start(start_a), .stop(stop_a), .timeout(timeout_a), .busy(busy_a)
  );

  i2c_slave_regif_ext #(
    .OFFSET_BYTES(2), .AUTO_INC(1), .FILT_DEPTH(3), .TIMEOUT_CYC(100)
  ) u_b (
    .clk(clk), .nrst(nrst),
    .i2c_slave_addr(7'h50), .addr_mask(7'h00),
    .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe_b),
    .offset(offset_b), .wr_data(wr_data_b), .wr_en(wr_en_b),
    .rd_en(rd_en_b), .rd_data(rd_data_b), .addr_hit(addr_hit_b),
    .start(start_b), .stop(stop_b), .timeout(timeout_b), .busy(busy_b)
  );

  // register bank model for A
  always_comb begin
    rd_data_a = 8'hEE;
    if (offset_a == 8'h20) rd_data_a = 8'h3C;
    if (offset_a == 8'h21) rd_data_a = 8'hC3;
  end
  assign rd_data_b = 8'h00;

  // event logs
  logic [15:0] wr_a[$];
  logic [23:0] wr_b[$];
  logic [7:0]  rd_a[$];
  int start_cnt_a = 0, stop_cnt_a = 0, to_cnt_b = 0, oe_cnt_a = 0;

  always @(negedge clk) begin
    if (wr_en_a) wr_a.push_back({offset_a, wr_data_a});
    if (wr_en_b) wr_b.push_back({offset_b, wr_data_b});
    if (rd_en_a) rd_a.push_back(offset_a);
    if (start_a) start_cnt_a++;
    if (stop_a) stop_cnt_a++;
    if (timeout_b) to_cnt_b++;
    if (sda_oe_a) oe_cnt_a++;
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    clk_n(Q); sda_m = 1'b1;
    clk_n(Q); scl_m = 1'b1;
    clk_n(2*Q); sda_m = 1'b0;
    clk_n(2*Q); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    clk_n(Q); sda_m = 1'b0;
    clk_n(Q); scl_m = 1'b1;
    clk_n(2*Q); sda_m = 1'b1;
    clk_n(2*Q);
  endtask

  task automatic bit_out(input logic b, output logic r);
    clk_n(Q); sda_m = b;
    clk_n(Q); scl_m = 1'b1;
    clk_n(Q); r = sda_bus;
    clk_n(Q); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gbit, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      if (i == gbit) begin
        clk_n(8); scl_m = 1'b1;
        clk_n(1); scl_m = 1'b0;
      end
      bit_out(d[i], r);
    end
    bit_out(1'b1, ack);
  endtask

  task automatic recv_byte(input logic ack_drv, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_out(1'b1, r);
      d[i] = r;
    end
    bit_out(ack_drv, r);
  endtask

  task automatic test_reset();
    nrst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    addr_a = 7'h28; mask_a = 7'h00;
    clk_n(3);
    checks++;
    if ({sda_oe_a, wr_en_a, rd_en_a, busy_a} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=0000", {sda_oe_a, wr_en_a, rd_en_a, busy_a});
    end
    checks++;
    if ({offset_a, wr_data_a, addr_hit_a} !== 23'h0) begin
      failures++;
      $display("FAIL reset_regs got=%h/%h/%h exp=0", offset_a, wr_data_a, addr_hit_a);
    end
    checks++;
    if ({start_a, stop_a, timeout_a, timeout_b, busy_b} !== 5'b0) begin
      failures++;
      $display("FAIL reset_pulses got=%b exp=00000", {start_a, stop_a, timeout_a, timeout_b, busy_b});
    end
    checks++;
    if (offset_b !== 16'h0) begin
      failures++;
      $display("FAIL reset_off_b got=%h exp=0000", offset_b);
    end
    nrst = 1'b1;
    clk_n(10);
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3;
    int n0, s0, p0;
    n0 = wr_a.size(); s0 = start_cnt_a; p0 = stop_cnt_a;
    i2c_start();
    send_byte(8'h50, -1, a0);
    send_byte(8'h10, -1, a1);
    send_byte(8'hA5, -1, a2);
    send_byte(8'h5A, -1, a3);
    i2c_stop();
    clk_n(4);
    checks++;
    if ({a0, a1, a2, a3} !== 4'b0000) begin
      failures++;
      $display("FAIL write_acks got=%b exp=0000", {a0, a1, a2, a3});
    end
    checks++;
    if (wr_a.size() != n0 + 2) begin
      failures++;
      $display("FAIL write_count got=%0d exp=%0d", wr_a.size() - n0, 2);
    end else begin
      checks++;
      if (wr_a[n0] !== 16'h10A5) begin
        failures++;
        $display("FAIL write_first got=%h exp=10a5", wr_a[n0]);
      end
      checks++;
      if (wr_a[n0+1] !== 16'h115A) begin
        failures++;
        $display("FAIL write_second got=%h exp=115a", wr_a[n0+1]);
      end
    end
    checks++;
    if (addr_hit_a !== 7'h28) begin
      failures++;
      $display("FAIL write_addr_hit got=%h exp=28", addr_hit_a);
    end
    checks++;
    if (offset_a !== 8'h12 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL write_end got=off %h busy %b exp=off 12 busy 0", offset_a, busy_a);
    end
    checks++;
    if (start_cnt_a != s0 + 1 || stop_cnt_a != p0 + 1) begin
      failures++;
      $display("FAIL write_pulses got=%0d/%0d exp=1/1", start_cnt_a - s0, stop_cnt_a - p0);
    end
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] d0, d1, d2;
    int n0, w0;
    n0 = rd_a.size(); w0 = wr_a.size();
    i2c_start();
    send_byte(8'h50, -1, a0);
    send_byte(8'h20, -1, a1);
    i2c_start();
    send_byte(8'h51, -1, a2);
    recv_byte(1'b0, d0);
    recv_byte(1'b1, d1);
    checks++;
    if ({a0, a1, a2} !== 3'b000) begin
      failures++;
      $display("FAIL read_acks got=%b exp=000", {a0, a1, a2});
    end
    checks++;
    if (d0 !== 8'h3C || d1 !== 8'hC3) begin
      failures++;
      $display("FAIL read_data got=%h,%h exp=3c,c3", d0, d1);
    end
    checks++;
    if (rd_a.size() != n0 + 2) begin
      failures++;
      $display("FAIL read_rd_en_count got=%0d exp=2", rd_a.size() - n0);
    end else begin
      checks++;
      if (rd_a[n0] !== 8'h20 || rd_a[n0+1] !== 8'h21) begin
        failures++;
        $display("FAIL read_offsets got=%h,%h exp=20,21", rd_a[n0], rd_a[n0+1]);
      end
    end
    checks++;
    if (busy_a !== 1'b1 || sda_oe_a !== 1'b0) begin
      failures++;
      $display("FAIL read_nack_state got=busy %b oe %b exp=busy 1 oe 0", busy_a, sda_oe_a);
    end
    recv_byte(1'b1, d2);
    checks++;
    if (d2 !== 8'hFF || rd_a.size() != n0 + 2) begin
      failures++;
      $display("FAIL read_ignore got=%h rd_en %0d exp=ff rd_en 2", d2, rd_a.size() - n0);
    end
    i2c_stop();
    clk_n(4);
    checks++;
    if (wr_a.size() != w0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL read_end got=wr %0d busy %b exp=wr 0 busy 0", wr_a.size() - w0, busy_a);
    end
  endtask

  task automatic test_mask();
    logic a0, a1;
    int c0;
    addr_a = 7'h30; mask_a = 7'h03;
    clk_n(4);
    i2c_start();
    send_byte(8'h66, -1, a0);
    i2c_stop();
    checks++;
    if (a0 !== 1'b0 || addr_hit_a !== 7'h33) begin
      failures++;
      $display("FAIL mask_hit got=ack %b hit %h exp=ack 0 hit 33", a0, addr_hit_a);
    end
    c0 = oe_cnt_a;
    i2c_start();
    send_byte(8'h68, -1, a1);
    i2c_stop();
    checks++;
    if (a1 !== 1'b1 || oe_cnt_a != c0) begin
      failures++;
      $display("FAIL mask_miss got=ack %b oe_cycles %0d exp=ack 1 oe_cycles 0", a1, oe_cnt_a - c0);
    end
    checks++;
    if (addr_hit_a !== 7'h33) begin
      failures++;
      $display("FAIL mask_hit_kept got=%h exp=33", addr_hit_a);
    end
    addr_a = 7'h28; mask_a = 7'h00;
    clk_n(4);
  endtask

  task automatic test_glitch();
    logic a0, a1, a2;
    int n0;
    n0 = wr_a.size();
    i2c_start();
    send_byte(8'h50, -1, a0);
    send_byte(8'h40, -1, a1);
    send_byte(8'h96, 4, a2);
    i2c_stop();
    clk_n(4);
    checks++;
    if ({a0, a1, a2} !== 3'b000) begin
      failures++;
      $display("FAIL glitch_acks got=%b exp=000", {a0, a1, a2});
    end
    checks++;
    if (wr_a.size() != n0 + 1) begin
      failures++;
      $display("FAIL glitch_count got=%0d exp=1", wr_a.size() - n0);
    end else begin
      checks++;
      if (wr_a[n0] !== 16'h4096) begin
        failures++;
        $display("FAIL glitch_data got=%h exp=4096", wr_a[n0]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [4:0] a;
    int n0;
    n0 = wr_b.size();
    i2c_start();
    send_byte(8'hA0, -1, a[4]);
    send_byte(8'hFF, -1, a[3]);
    send_byte(8'hFF, -1, a[2]);
    send_byte(8'h11, -1, a[1]);
    send_byte(8'h22, -1, a[0]);
    i2c_stop();
    clk_n(4);
    checks++;
    if (a !== 5'b0) begin
      failures++;
      $display("FAIL wrap_acks got=%b exp=00000", a);
    end
    checks++;
    if (wr_b.size() != n0 + 2) begin
      failures++;
      $display("FAIL wrap_count got=%0d exp=2", wr_b.size() - n0);
    end else begin
      checks++;
      if (wr_b[n0] !== 24'hFFFF11 || wr_b[n0+1] !== 24'h000022) begin
        failures++;
        $display("FAIL wrap_data got=%h,%h exp=ffff11,000022", wr_b[n0], wr_b[n0+1]);
      end
    end
  endtask

  task automatic test_timeout();
    logic a0, a1, a2, r;
    logic [7:0] d;
    int n0, t0;
    n0 = wr_b.size(); t0 = to_cnt_b;
    d = 8'hCC;
    i2c_start();
    send_byte(8'hA0, -1, a0);
    send_byte(8'h00, -1, a1);
    send_byte(8'h01, -1, a2);
    for (int i = 7; i >= 4; i--) bit_out(d[i], r);
    checks++;
    if (busy_b !== 1'b1) begin
      failures++;
      $display("FAIL timeout_pre_busy got=%b exp=1", busy_b);
    end
    clk_n(130);
    checks++;
    if (to_cnt_b != t0 + 1) begin
      failures++;
      $display("FAIL timeout_pulse got=%0d exp=1", to_cnt_b - t0);
    end
    checks++;
    if (busy_b !== 1'b0 || sda_oe_b !== 1'b0) begin
      failures++;
      $display("FAIL timeout_state got=busy %b oe %b exp=0 0", busy_b, sda_oe_b);
    end
    i2c_stop();
    clk_n(4);
    checks++;
    if (wr_b.size() != n0 || {a0, a1, a2} !== 3'b000) begin
      failures++;
      $display("FAIL timeout_no_wr got=wr %0d acks %b exp=wr 0 acks 000", wr_b.size() - n0, {a0, a1, a2});
    end
  endtask

  task automatic test_reset_mid_read();
    logic a0, r;
    i2c_start();
    send_byte(8'h51, -1, a0);
    for (int i = 0; i < 3; i++) bit_out(1'b1, r);
    clk_n(Q);
    checks++;
    if (a0 !== 1'b0 || sda_oe_a !== 1'b1 || busy_a !== 1'b1) begin
      failures++;
      $display("FAIL midread_pre got=ack %b oe %b busy %b exp=0 1 1", a0, sda_oe_a, busy_a);
    end
    nrst = 1'b0;
    clk_n(2);
    checks++;
    if ({sda_oe_a, wr_en_a, rd_en_a, busy_a, start_a, stop_a} !== 6'b0) begin
      failures++;
      $display("FAIL midread_ctl got=%b exp=000000", {sda_oe_a, wr_en_a, rd_en_a, busy_a, start_a, stop_a});
    end
    checks++;
    if ({offset_a, wr_data_a, addr_hit_a} !== 23'h0) begin
      failures++;
      $display("FAIL midread_regs got=%h/%h/%h exp=0", offset_a, wr_data_a, addr_hit_a);
    end
    scl_m = 1'b1; sda_m = 1'b1;
    clk_n(2);
    nrst = 1'b1;
    clk_n(20);
    checks++;
    if (busy_a !== 1'b0 || start_a !== 1'b0) begin
      failures++;
      $display("FAIL midread_after got=busy %b start %b exp=0 0", busy_a, start_a);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mask();
    test_glitch();
    test_wrap();
    test_timeout();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
